// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the multicycle next-PC sequencer: branch encodings,
// FSM states and default reset/exception addresses.
package pc_sequencer_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [XLEN-1:0] RESET_PC_DEF   = 32'h0040_0000;
   localparam logic [XLEN-1:0] EXC_VECTOR_DEF = 32'h0040_0004;

   // Control-flow class reported by execute alongside ex_done
   typedef enum logic [2:0] {
      BR_SEQ  = 3'd0,
      BR_BEQ  = 3'd1,
      BR_BNE  = 3'd2,
      BR_BGEZ = 3'd3,
      BR_BLTZ = 3'd4,
      BR_J    = 3'd5,
      BR_JR   = 3'd6,
      BR_ERET = 3'd7
   } br_type_e;

   // Instruction phases of the multicycle core
   typedef enum logic [1:0] {
      ST_FETCH  = 2'd0,
      ST_EXEC   = 2'd1,
      ST_UPDATE = 2'd2
   } state_e;

endpackage

// File: rtl/pc_sequencer_branch_calc.sv
// Branch and jump target arithmetic (the branch_target_calc block).
module pc_sequencer_branch_calc
   import pc_sequencer_pkg::*;
(
   input  logic [XLEN-1:0] pc_plus4,
   input  logic [15:0]     imm16,
   input  logic [25:0]     idx26,
   output logic [XLEN-1:0] br_tgt,
   output logic [XLEN-1:0] j_tgt
);

   // Sign-extended word offset relative to the following instruction; wraps mod 2^32
   assign br_tgt = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};

   // Pseudo-direct jump within the current 256 MB region
   assign j_tgt  = {pc_plus4[31:28], idx26, 2'b00};

endmodule

// File: rtl/pc_sequencer.sv
// Multicycle next-PC controller: fetch, wait for execute, then commit the next PC.
// Sole writer of the PC register; also maintains EPC for exceptions and eret.
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEF,
   parameter logic [XLEN-1:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
   input  logic            clk,
   input  logic            rst,
   output logic            if_req,
   input  logic            if_ack,
   input  logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] ir,
   input  logic            ex_done,
   input  logic [2:0]      br_type,
   input  logic            a_eq_b,
   input  logic            a_neg,
   input  logic [XLEN-1:0] rs_val,
   input  logic            exc_req,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] link_addr,
   output logic [XLEN-1:0] epc,
   output logic            redirect,
   output logic            adel
);

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] ir_q, ir_d;
   logic [XLEN-1:0] epc_q, epc_d;
   logic [XLEN-1:0] npc_q, npc_d;
   logic            redirect_q, redirect_d;
   logic            adel_q, adel_d;

   br_type_e        br_e;
   logic [XLEN-1:0] pc_plus4;
   logic [XLEN-1:0] br_tgt;
   logic [XLEN-1:0] j_tgt;
   logic            br_taken;
   logic            jr_misaligned;
   logic            take_exc;
   logic [XLEN-1:0] npc_sel;

   assign br_e     = br_type_e'(br_type);
   assign pc_plus4 = pc_q + 32'd4;

   pc_sequencer_branch_calc u_branch_calc (
      .pc_plus4 (pc_plus4),
      .imm16    (ir_q[15:0]),
      .idx26    (ir_q[25:0]),
      .br_tgt   (br_tgt),
      .j_tgt    (j_tgt)
   );

   // Conditional branch resolution from the execute compare flags
   always_comb begin
      br_taken = 1'b0;
      case (br_e)
         BR_BEQ:  br_taken = a_eq_b;
         BR_BNE:  br_taken = !a_eq_b;
         BR_BGEZ: br_taken = !a_neg;
         BR_BLTZ: br_taken = a_neg;
         default: br_taken = 1'b0;
      endcase
   end

   assign jr_misaligned = (br_e == BR_JR) && (rs_val[1:0] != 2'b00);
   assign take_exc      = exc_req || jr_misaligned;

   // Next-PC priority mux: exception, bad JR, eret, jr, j, taken branch, sequential
   always_comb begin
      npc_sel = pc_plus4;
      if (take_exc)              npc_sel = EXC_VECTOR;
      else if (br_e == BR_ERET)  npc_sel = epc_q;
      else if (br_e == BR_JR)    npc_sel = rs_val;
      else if (br_e == BR_J)     npc_sel = j_tgt;
      else if (br_taken)         npc_sel = br_tgt;
   end

   // FSM next state and register updates
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ir_d       = ir_q;
      epc_d      = epc_q;
      npc_d      = npc_q;
      redirect_d = 1'b0;
      adel_d     = 1'b0;
      case (state_q)
         ST_FETCH: begin
            if (if_ack) begin
               ir_d    = instr;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (ex_done) begin
               npc_d      = npc_sel;
               if (take_exc) epc_d = pc_q;
               redirect_d = (npc_sel != pc_plus4);
               adel_d     = jr_misaligned && !exc_req;
               state_d    = ST_UPDATE;
            end
         end
         ST_UPDATE: begin
            pc_d    = npc_q;
            state_d = ST_FETCH;
         end
         default: state_d = ST_FETCH;
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_FETCH;
         pc_q       <= RESET_PC;
         ir_q       <= '0;
         epc_q      <= '0;
         npc_q      <= '0;
         redirect_q <= 1'b0;
         adel_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         ir_q       <= ir_d;
         epc_q      <= epc_d;
         npc_q      <= npc_d;
         redirect_q <= redirect_d;
         adel_q     <= adel_d;
      end
   end

   assign if_req    = (state_q == ST_FETCH);
   assign pc        = pc_q;
   assign ir        = ir_q;
   assign epc       = epc_q;
   assign link_addr = pc_plus4;
   assign redirect  = redirect_q;
   assign adel      = adel_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: walks a fixed instruction sequence with
// hand-computed PC/EPC/redirect/adel expectations, then resets mid-execute.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic        if_ack;
   logic [31:0] instr;
   logic [31:0] ir;
   logic        ex_done;
   logic [2:0]  br_type;
   logic        a_eq_b;
   logic        a_neg;
   logic [31:0] rs_val;
   logic        exc_req;
   logic [31:0] pc;
   logic [31:0] link_addr;
   logic [31:0] epc;
   logic        redirect;
   logic        adel;

   int          n_checks = 0;
   int          n_err    = 0;
   logic [31:0] cur_pc;
   logic [31:0] cur_ir;

   localparam logic [31:0] RST_PC = 32'h0040_0000;
   localparam logic [31:0] EXC_PC = 32'h0040_0004;

   pc_sequencer dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_ack    (if_ack),
      .instr     (instr),
      .ir        (ir),
      .ex_done   (ex_done),
      .br_type   (br_type),
      .a_eq_b    (a_eq_b),
      .a_neg     (a_neg),
      .rs_val    (rs_val),
      .exc_req   (exc_req),
      .pc        (pc),
      .link_addr (link_addr),
      .epc       (epc),
      .redirect  (redirect),
      .adel      (adel)
   );

   always #5 clk = ~clk;

   // Single comparison point for the whole bench
   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // One full instruction: fetch (ack after ack_dly), execute (done after done_dly), update
   task automatic run_instr(input string tag, input logic [31:0] i, input logic [2:0] bt,
                            input logic eq, input logic neg, input logic [31:0] rsv,
                            input logic exc, input int ack_dly, input int done_dly,
                            input logic [31:0] exp_pc, input logic exp_redir,
                            input logic exp_adel, input logic [31:0] exp_epc);
      check({tag, ":if_req"}, 32'(if_req), 32'd1);
      check({tag, ":link"}, link_addr, cur_pc + 32'd4);
      instr = i;
      for (int k = 0; k < ack_dly; k++) begin
         if_ack = 1'b0;
         @(negedge clk);
         check({tag, ":ir_hold"}, ir, cur_ir);
         check({tag, ":req_hold"}, 32'(if_req), 32'd1);
      end
      if_ack = 1'b1;
      @(negedge clk);
      if_ack = 1'b0;
      instr  = 32'hFFFF_FFFF;
      cur_ir = i;
      check({tag, ":ir"}, ir, cur_ir);
      check({tag, ":req_exec"}, 32'(if_req), 32'd0);
      br_type = bt;
      a_eq_b  = eq;
      a_neg   = neg;
      rs_val  = rsv;
      exc_req = exc;
      for (int k = 0; k < done_dly; k++) begin
         ex_done = 1'b0;
         if_ack  = 1'b1;
         @(negedge clk);
         check({tag, ":ir_exec_ack"}, ir, cur_ir);
         check({tag, ":pc_exec"}, pc, cur_pc);
      end
      if_ack  = 1'b0;
      ex_done = 1'b1;
      @(negedge clk);
      ex_done = 1'b0;
      exc_req = 1'b0;
      br_type = 3'd0;
      check({tag, ":redirect"}, 32'(redirect), 32'(exp_redir));
      check({tag, ":adel"}, 32'(adel), 32'(exp_adel));
      check({tag, ":pc_upd"}, pc, cur_pc);
      @(negedge clk);
      check({tag, ":pc"}, pc, exp_pc);
      check({tag, ":epc"}, epc, exp_epc);
      check({tag, ":redir_clr"}, 32'(redirect), 32'd0);
      check({tag, ":adel_clr"}, 32'(adel), 32'd0);
      cur_pc = exp_pc;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; if_ack = 1'b0; instr = '0; ex_done = 1'b0; br_type = 3'd0;
      a_eq_b = 1'b0; a_neg = 1'b0; rs_val = '0; exc_req = 1'b0;
      repeat (2) @(negedge clk);
      rst    = 1'b0;
      cur_pc = RST_PC;
      cur_ir = '0;
      check("rst:pc", pc, RST_PC);
      check("rst:if_req", 32'(if_req), 32'd1);
      check("rst:epc", epc, 32'd0);
      check("rst:redirect", 32'(redirect), 32'd0);
      check("rst:adel", 32'(adel), 32'd0);
      check("rst:ir", ir, 32'd0);

      //         tag       instr          bt    eq    neg   rs_val         exc  ack dne exp_pc         rd    ad    epc
      run_instr("jr10a",   32'h0000_0008, 3'd6, 1'b0, 1'b0, 32'h0040_0010, 1'b0, 0, 0, 32'h0040_0010, 1'b1, 1'b0, 32'h0);
      run_instr("beq_t",   32'h1000_FFFC, 3'd1, 1'b1, 1'b0, 32'h0,         1'b0, 0, 0, 32'h0040_0004, 1'b1, 1'b0, 32'h0);
      run_instr("jr10b",   32'h0000_0008, 3'd6, 1'b0, 1'b0, 32'h0040_0010, 1'b0, 0, 0, 32'h0040_0010, 1'b1, 1'b0, 32'h0);
      run_instr("beq_nt",  32'h1000_FFFC, 3'd1, 1'b0, 1'b0, 32'h0,         1'b0, 0, 0, 32'h0040_0014, 1'b0, 1'b0, 32'h0);
      run_instr("j_a",     32'h0810_0008, 3'd5, 1'b0, 1'b0, 32'h0,         1'b0, 0, 0, 32'h0040_0020, 1'b1, 1'b0, 32'h0);
      run_instr("j_self",  32'h0810_0008, 3'd5, 1'b0, 1'b0, 32'h0,         1'b0, 0, 0, 32'h0040_0020, 1'b1, 1'b0, 32'h0);
      run_instr("jr_adel", 32'h0000_0008, 3'd6, 1'b0, 1'b0, 32'h0040_0102, 1'b0, 0, 0, EXC_PC,        1'b1, 1'b1, 32'h0040_0020);
      run_instr("eret",    32'h4200_0018, 3'd7, 1'b0, 1'b0, 32'h0,         1'b0, 0, 0, 32'h0040_0020, 1'b1, 1'b0, 32'h0040_0020);
      run_instr("seq24",   32'h0000_0000, 3'd0, 1'b0, 1'b0, 32'h0,         1'b0, 0, 0, 32'h0040_0024, 1'b0, 1'b0, 32'h0040_0020);
      run_instr("bne_exc", 32'h1400_0010, 3'd2, 1'b0, 1'b0, 32'h0,         1'b1, 0, 0, EXC_PC,        1'b1, 1'b0, 32'h0040_0024);
      run_instr("bgez_t",  32'h0401_0002, 3'd3, 1'b0, 1'b0, 32'h0,         1'b0, 0, 0, 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0024);
      run_instr("bltz_nt", 32'h0400_0000, 3'd4, 1'b0, 1'b0, 32'h0,         1'b0, 0, 0, 32'h0040_0014, 1'b0, 1'b0, 32'h0040_0024);
      run_instr("bltz_bk", 32'h0400_FFFF, 3'd4, 1'b0, 1'b1, 32'h0,         1'b0, 0, 0, 32'h0040_0014, 1'b1, 1'b0, 32'h0040_0024);
      run_instr("late",    32'h2108_0001, 3'd0, 1'b0, 1'b0, 32'h0,         1'b0, 5, 2, 32'h0040_0018, 1'b0, 1'b0, 32'h0040_0024);
      run_instr("jr_top",  32'h0000_0008, 3'd6, 1'b0, 1'b0, 32'hFFFF_FFFC, 1'b0, 0, 0, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0040_0024);
      run_instr("wrap",    32'h0000_0000, 3'd0, 1'b0, 1'b0, 32'h0,         1'b0, 0, 0, 32'h0000_0000, 1'b0, 1'b0, 32'h0040_0024);

      // Reset arriving in EXEC together with ex_done on a misaligned jr
      instr  = 32'h1234_5678;
      if_ack = 1'b1;
      @(negedge clk);
      if_ack  = 1'b0;
      check("rx:ir", ir, 32'h1234_5678);
      ex_done = 1'b1;
      br_type = 3'd6;
      rs_val  = 32'h0000_1001;
      rst     = 1'b1;
      @(negedge clk);
      rst     = 1'b0;
      ex_done = 1'b0;
      br_type = 3'd0;
      check("rx:pc", pc, RST_PC);
      check("rx:redirect", 32'(redirect), 32'd0);
      check("rx:adel", 32'(adel), 32'd0);
      check("rx:ir0", ir, 32'd0);
      check("rx:epc", epc, 32'd0);
      check("rx:if_req", 32'(if_req), 32'd1);
      @(negedge clk);
      check("rx:redirect2", 32'(redirect), 32'd0);
      check("rx:pc2", pc, RST_PC);
      check("rx:if_req2", 32'(if_req), 32'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
